dm_access_unit: RTL
===================

// Module: dm_access_unit
// PURPOSE
// - Data-memory responder for the EX-stage memory controls (dm_web_ex, is_load_ex, is_store_ex).
// - Latches one load/store request. Drives the SRAM port with active-low chip, write and byte enables.
// - For loads, waits the SRAM read latency, then extracts, sign- or zero-extends and returns the word.
// - Holds the pipeline through stall while an access is in flight. Sits between the EX/MEM boundary and the DM SRAM macro.
// PARAMETERS
// - ADDR_W        32  byte-address width
// - READ_LATENCY  1   cycles from SRAM address (ACCESS cycle) to valid dm_do; legal range 1..7
// PORTS
// - clk         in   1       single clock, rising edge
// - rst         in   1       synchronous reset, active-low (0 = reset, sampled on clk)
// - dm_web_ex   in   1       0 = store request, 1 = read/none
// - is_store_ex in   2       01 SW, 10 SH, 11 SB, 00 none
// - is_load_ex  in   3       001 LB, 010 LH, 011 LW/FLW, 100 LBU, 101 LHU, 000 none
// - addr_ex     in   ADDR_W  effective byte address
// - wdata_ex    in   32      store data, right-justified
// - stall       out  1       1 = freeze pipeline
// - load_valid  out  1       one-cycle pulse, load_data valid
// - load_data   out  32      extended load result
// - store_done  out  1       one-cycle pulse, store committed
// - misalign    out  1       one-cycle pulse, request dropped
// - dm_ceb      out  1       SRAM chip enable, active-low
// - dm_web      out  1       SRAM write enable, active-low
// - dm_bweb     out  4       SRAM byte write enables, active-low, bit i = byte lane i
// - dm_addr     out  ADDR_W-2  SRAM word address
// - dm_di       out  32      SRAM write data, lane-aligned
// - dm_do       in   32      SRAM read data
// BEHAVIOUR
// - Reset (rst=0 at an edge), applies also mid-operation:
//   - state=IDLE, all pulses 0, stall=0, load_data=0.
//   - dm_ceb=1, dm_web=1, dm_bweb=4'hF, dm_addr=0, dm_di=0.
//   - An in-flight access is abandoned; no SRAM write occurs.
// - FSM states: IDLE, ACCESS, WAIT, RESP. Outputs are registered.
// - IDLE:
//   - A request is a store (dm_web_ex==0 && is_store_ex!=0) or a load (is_load_ex!=0).
//   - If a request is present at an edge: latch addr/type/data.
//     - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Pulse misalign next cycle and stay IDLE.
//     - Otherwise go to ACCESS.
//   - Requests arriving outside IDLE are ignored; stall guarantees the pipeline holds them.
// - Store and load both nonzero: store wins, and misalign pulses with it as an illegal-combination flag.
// - ACCESS (1 cycle): dm_ceb=0, dm_addr=addr[ADDR_W-1:2].
//   - Store: dm_web=0, store_done=1, next state IDLE.
//   - Store lanes: SW bweb=0000; SH bweb=~(4'b0011<<addr[1:0]); SB bweb=~(4'b0001<<addr[1:0]).
//   - Store data: dm_di = wdata replicated per width, shifted by 8*addr[1:0].
//   - Load: dm_web=1, bweb=4'hF. Next state WAIT if READ_LATENCY>1, else RESP.
// - WAIT: a counter counts READ_LATENCY-1 cycles with dm_ceb=1, then goes to RESP.
// - RESP (1 cycle):
//   - Sample dm_do and select the lane by addr[1:0].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//   - load_valid=1, next state IDLE.
// - stall=1 in ACCESS and WAIT, 0 otherwise.
// - Load latency: accept edge to load_valid = 1+READ_LATENCY cycles. Store: store_done 1 cycle after accept.
// - Back-to-back: a request held during RESP or a store ACCESS is accepted on the edge leaving that state into IDLE.
//   - Each access therefore occupies a minimum of 2 cycles.
// STRUCTURE
// - lsu_pkg: typedef enum for store_t (NONE, SW, SH, SB) and load_t (NONE, LB, LH, LW, LBU, LHU) with the encodings above.
// - lsu_pkg also holds: dm_state_t (IDLE, ACCESS, WAIT, RESP) and the constant BWEB_NONE=4'hF.
// - Sub-module load_align (combinational): inputs dm_do, addr[1:0], load_t; output 32-bit extended result.
//   - Reused by the verification model.
// - Wait counter: 3 bits, cleared on entering ACCESS.
// TESTING
// - Reset mid-WAIT:
//   - Stimulus: LW @0x10, READ_LATENCY=3, rst=0 for 1 cycle during WAIT.
//   - Response: no load_valid, stall=0 the next cycle, dm_web stays 1 throughout.
// - SB store:
//   - Stimulus: SB addr=0x7, wdata=0x000000A5.
//   - Response: ACCESS cycle has dm_addr=0x1, bweb=4'b0111, dm_di[31:24]=0xA5, dm_web=0; store_done 1 cycle after accept.
// - Load extension: dm_do=0x80FF7F01.
//   - LB@0x3 -> 0xFFFFFF80.
//   - LBU@0x3 -> 0x00000080.
//   - LH@0x2 -> 0xFFFF80FF.
//   - LHU@0x0 -> 0x00007F01.
//   - LW@0x0 -> 0x80FF7F01.
// - Misalign:
//   - SH@0x1 -> misalign pulse, dm_ceb stays 1, no store_done.
//   - LW@0x2 -> misalign pulse, no load_valid.
// - Latency sweep: READ_LATENCY=1,2,4 with LW -> load_valid exactly 2,3,5 cycles after the accept edge; stall high for 1,2,4 cycles.
// - Back-to-back: SW@0x20 then LW@0x20 held by stall -> LW accepted after store_done; load_data equals the stored word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the data-memory access unit.
//   store_t / load_t : EX-stage memory op encodings
//   dm_state_t       : access FSM states
//   BWEB_NONE        : byte-write-enable value with every lane masked
//   st_misaligned / ld_misaligned : alignment rules by access width
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SW   = 2'b01,
    ST_SH   = 2'b10,
    ST_SB   = 2'b11
  } store_t;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } load_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } dm_state_t;

  localparam logic [3:0] BWEB_NONE = 4'hF;

  function automatic logic st_misaligned(store_t t, logic [1:0] off);
    return ((t == ST_SH) && off[0]) || ((t == ST_SW) && (off != 2'b00));
  endfunction

  // Unlisted load codes fall into the word case, the strictest rule.
  function automatic logic ld_misaligned(load_t t, logic [1:0] off);
    case (t)
      LD_LB, LD_LBU: return 1'b0;
      LD_LH, LD_LHU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_load_align.sv
// Combinational load lane select and extension.
//   dm_do    : raw SRAM word
//   byte_off : byte offset within the word (addr[1:0])
//   ld_type  : load kind; signed kinds sign-extend, U kinds zero-extend
//   result   : extended load value; word loads pass through
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] dm_do,
  input  logic [1:0]  byte_off,
  input  load_t       ld_type,
  output logic [31:0] result
);

  logic [31:0] sh;
  assign sh = dm_do >> {byte_off, 3'b000};

  always_comb begin
    case (ld_type)
      LD_LB:   result = {{24{sh[7]}}, sh[7:0]};
      LD_LBU:  result = {24'h0, sh[7:0]};
      LD_LH:   result = {{16{sh[15]}}, sh[15:0]};
      LD_LHU:  result = {16'h0, sh[15:0]};
      default: result = dm_do;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: accepts one EX-stage load/store, drives the DM
// SRAM macro (active-low enables), returns extended load data and stalls
// the pipeline while an access is in flight.
//   clk, rst             : clock, synchronous active-low reset
//   dm_web_ex, is_store_ex, is_load_ex, addr_ex, wdata_ex : request
//   stall                : freeze pipeline (ACCESS/WAIT)
//   load_valid/load_data : load result pulse
//   store_done           : store committed pulse
//   misalign             : request dropped (or illegal store+load combo)
//   dm_ceb, dm_web, dm_bweb, dm_addr, dm_di, dm_do : SRAM port
module dm_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_web_ex,
  input  logic [1:0]        is_store_ex,
  input  logic [2:0]        is_load_ex,
  input  logic [ADDR_W-1:0] addr_ex,
  input  logic [31:0]       wdata_ex,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              store_done,
  output logic              misalign,
  output logic              dm_ceb,
  output logic              dm_web,
  output logic [3:0]        dm_bweb,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_di,
  input  logic [31:0]       dm_do
);

  // WAIT lasts READ_LATENCY-1 cycles; the counter ends at READ_LATENCY-2.
  localparam int         WL        = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [2:0] WAIT_LAST = 3'(WL);

  dm_state_t state, state_d;
  logic [2:0] cnt;
  logic [1:0] off_q;
  store_t     st_q;
  load_t      ld_q;

  store_t st_in;
  load_t  ld_in;
  logic   req_store, req_load, bad, can_accept, accept_go, accept_bad;
  logic [31:0] algn;

  logic              stall_d, lv_d, sd_d, mis_d, ceb_d, web_d;
  logic [31:0]       ld_d, di_d;
  logic [3:0]        bweb_d;
  logic [ADDR_W-3:0] daddr_d;

  assign st_in     = store_t'(is_store_ex);
  assign ld_in     = load_t'(is_load_ex);
  assign req_store = !dm_web_ex && (st_in != ST_NONE);
  assign req_load  = ld_in != LD_NONE;
  // Store wins over a simultaneous load, so its alignment rule applies.
  assign bad       = req_store ? st_misaligned(st_in, addr_ex[1:0])
                               : ld_misaligned(ld_in, addr_ex[1:0]);
  // Accept on the edge that lands in IDLE as well as from IDLE itself.
  assign can_accept = (state == IDLE) || (state == RESP) ||
                      ((state == ACCESS) && (st_q != ST_NONE));
  assign accept_go  = can_accept && (req_store || req_load) && !bad;
  assign accept_bad = can_accept && (req_store || req_load) && bad;

  load_align u_align (
    .dm_do    (dm_do),
    .byte_off (off_q),
    .ld_type  (ld_q),
    .result   (algn)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      off_q      <= 2'b00;
      st_q       <= ST_NONE;
      ld_q       <= LD_NONE;
      stall      <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= 32'h0;
      store_done <= 1'b0;
      misalign   <= 1'b0;
      dm_ceb     <= 1'b1;
      dm_web     <= 1'b1;
      dm_bweb    <= BWEB_NONE;
      dm_addr    <= '0;
      dm_di      <= 32'h0;
    end else begin
      state <= state_d;
      if (accept_go) begin
        cnt   <= 3'd0;
        off_q <= addr_ex[1:0];
        st_q  <= req_store ? st_in : ST_NONE;
        ld_q  <= req_store ? LD_NONE : ld_in;
      end else if (state == WAIT) begin
        cnt <= cnt + 3'd1;
      end
      stall      <= stall_d;
      load_valid <= lv_d;
      load_data  <= ld_d;
      store_done <= sd_d;
      misalign   <= mis_d;
      dm_ceb     <= ceb_d;
      dm_web     <= web_d;
      dm_bweb    <= bweb_d;
      dm_addr    <= daddr_d;
      dm_di      <= di_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept_go ? ACCESS : IDLE;
      ACCESS:  if (st_q != ST_NONE) state_d = accept_go ? ACCESS : IDLE;
               else                 state_d = (READ_LATENCY > 1) ? WAIT : RESP;
      WAIT:    state_d = (cnt == WAIT_LAST) ? RESP : WAIT;
      RESP:    state_d = accept_go ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle.
  always_comb begin
    stall_d = 1'b0;
    lv_d    = 1'b0;
    ld_d    = load_data;
    sd_d    = 1'b0;
    mis_d   = 1'b0;
    ceb_d   = 1'b1;
    web_d   = 1'b1;
    bweb_d  = BWEB_NONE;
    daddr_d = dm_addr;
    di_d    = dm_di;

    if ((state == ACCESS) && (st_q == ST_NONE)) stall_d = READ_LATENCY > 1;
    if (state == WAIT) stall_d = cnt != WAIT_LAST;
    if (state == RESP) begin
      lv_d = 1'b1;
      ld_d = algn;
    end

    if (accept_bad) mis_d = 1'b1;
    if (accept_go) begin
      stall_d = 1'b1;
      ceb_d   = 1'b0;
      daddr_d = addr_ex[ADDR_W-1:2];
      if (req_store) begin
        web_d = 1'b0;
        sd_d  = 1'b1;
        mis_d = req_load;
        case (st_in)
          ST_SH: begin
            bweb_d = ~(4'b0011 << addr_ex[1:0]);
            di_d   = {2{wdata_ex[15:0]}} << {addr_ex[1:0], 3'b000};
          end
          ST_SB: begin
            bweb_d = ~(4'b0001 << addr_ex[1:0]);
            di_d   = {4{wdata_ex[7:0]}} << {addr_ex[1:0], 3'b000};
          end
          default: begin
            bweb_d = 4'b0000;
            di_d   = wdata_ex;
          end
        endcase
      end
    end
  end

endmodule
